// File: rtl/mono_rx_arbiter.sv
// ============================================================================
// Module      : mono_rx_arbiter
// Description : Round-robin burst arbiter merging NREQ FWFT source FIFOs into
//               a single one-word output stage, with a byte-wide register bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mono_rx_arbiter #(
   parameter int ABUSWIDTH = 16,
   parameter int NREQ      = 4,
   parameter int BURST     = 16,
   parameter int VERSION   = 1
) (
   input  logic                   BUS_CLK,
   input  logic                   BUS_RST,
   input  logic [ABUSWIDTH-1:0]   BUS_ADD,
   input  logic [7:0]             BUS_DATA_IN,
   output logic [7:0]             BUS_DATA_OUT,
   input  logic                   BUS_WR,
   input  logic                   BUS_RD,
   input  logic [NREQ-1:0]        REQ_EMPTY,
   input  logic [32*NREQ-1:0]     REQ_DATA,
   output logic [NREQ-1:0]        REQ_READ,
   input  logic                   FIFO_READ,
   output logic                   FIFO_EMPTY,
   output logic [31:0]            FIFO_DATA
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [NREQ-1:0] r_en_mask;
   logic [2:0]      r_grant;
   logic [2:0]      r_last_grant;
   logic [2:0]      w_pick;
   logic [7:0]      r_burst_cnt;
   logic            r_valid;
   logic [31:0]     r_data;
   logic [7:0]      r_word_cnt [NREQ];
   logic [7:0]      r_bus_data_out;
   logic [7:0]      w_rd_data;
   logic [7:0]      w_mask8;
   logic [NREQ-1:0] w_avail;
   logic [NREQ-1:0] w_req_read;
   logic [31:0]     w_g_data;
   logic            w_soft_rst;
   logic            w_rst;
   logic            w_any;
   logic            w_g_empty;
   logic            w_g_en;
   logic            w_out_ready;
   logic            w_pop;
   logic            w_burst_end;
   logic            w_unused_ok;

   assign w_soft_rst  = BUS_WR && (BUS_ADD == ABUSWIDTH'(0));
   assign w_rst       = BUS_RST | w_soft_rst;
   assign w_avail     = r_en_mask & ~REQ_EMPTY;
   assign w_out_ready = !r_valid || FIFO_READ;
   assign w_burst_end = (r_burst_cnt == 8'(BURST - 1));
   assign w_unused_ok = ^BUS_DATA_IN;

   // Round-robin pick: the smallest offset k from last_grant wins, so scan k downwards.
   always_comb begin
      w_any  = 1'b0;
      w_pick = r_grant;
      for (int k = NREQ; k >= 1; k--) begin
         for (int i = 0; i < NREQ; i++) begin
            if (w_avail[i] && (i == ((int'(r_last_grant) + k) % NREQ))) begin
               w_any  = 1'b1;
               w_pick = 3'(i);
            end
         end
      end
   end

   always_comb begin
      w_g_empty = 1'b1;
      w_g_en    = 1'b0;
      w_g_data  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (r_grant == 3'(i)) begin
            w_g_empty = REQ_EMPTY[i];
            w_g_en    = r_en_mask[i];
            w_g_data  = REQ_DATA[32*i +: 32];
         end
      end
   end

   // Pop is held off during any reset cycle so no word is lost to a flushed stage.
   assign w_pop = (r_state == ST_GRANT) && w_out_ready && !w_g_empty && w_g_en && !w_rst;

   always_comb begin
      w_req_read = '0;
      for (int i = 0; i < NREQ; i++) begin
         w_req_read[i] = w_pop && (r_grant == 3'(i));
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (w_any) w_state_nxt = ST_GRANT;
         ST_GRANT: if ((w_pop && w_burst_end) || w_g_empty || !w_g_en) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge BUS_CLK) begin
      if (w_rst) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_ff @(posedge BUS_CLK) begin
      if (w_rst) begin
         r_grant      <= 3'd0;
         r_last_grant <= 3'(NREQ - 1);
         r_burst_cnt  <= 8'd0;
         r_valid      <= 1'b0;
         r_data       <= 32'd0;
         r_en_mask    <= '0;
      end else begin
         if (r_state == ST_IDLE && w_any) begin
            r_grant     <= w_pick;
            r_burst_cnt <= 8'd0;
         end else if (w_pop) begin
            r_burst_cnt <= r_burst_cnt + 8'd1;
         end
         if (r_state == ST_GRANT && w_state_nxt == ST_IDLE) r_last_grant <= r_grant;
         if (w_pop) begin
            r_data  <= w_g_data;
            r_valid <= 1'b1;
         end else if (FIFO_READ) begin
            r_valid <= 1'b0;
         end
         if (BUS_WR && BUS_ADD == ABUSWIDTH'(1)) r_en_mask <= BUS_DATA_IN[NREQ-1:0];
      end
   end

   always_ff @(posedge BUS_CLK) begin
      for (int i = 0; i < NREQ; i++) begin
         if (w_rst)                                        r_word_cnt[i] <= 8'd0;
         else if (w_req_read[i] && r_word_cnt[i] != 8'hFF) r_word_cnt[i] <= r_word_cnt[i] + 8'd1;
      end
   end

   always_comb begin
      w_mask8              = '0;
      w_mask8[NREQ-1:0]    = r_en_mask;
      w_rd_data            = '0;
      if (BUS_ADD == ABUSWIDTH'(0))      w_rd_data = 8'(VERSION);
      else if (BUS_ADD == ABUSWIDTH'(1)) w_rd_data = w_mask8;
      else if (BUS_ADD == ABUSWIDTH'(2)) w_rd_data = {(r_state == ST_GRANT), 4'b0000, r_grant};
      for (int i = 0; i < NREQ; i++) begin
         if (BUS_ADD == ABUSWIDTH'(3 + i)) w_rd_data = r_word_cnt[i];
      end
   end

   // Read data survives soft reset; only the bus reset clears it.
   always_ff @(posedge BUS_CLK) begin
      if (BUS_RST)     r_bus_data_out <= 8'd0;
      else if (BUS_RD) r_bus_data_out <= w_rd_data;
   end

   assign BUS_DATA_OUT = r_bus_data_out;
   assign REQ_READ     = w_req_read;
   assign FIFO_EMPTY   = !r_valid;
   assign FIFO_DATA    = r_data;

endmodule

`default_nettype wire

// File: tb/tb_mono_rx_arbiter.sv
// ============================================================================
// Module      : tb_mono_rx_arbiter
// Description : Scoreboard bench for mono_rx_arbiter with FWFT source models.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mono_rx_arbiter;

   logic         BUS_CLK = 1'b0;
   logic         BUS_RST;
   logic [15:0]  BUS_ADD;
   logic [7:0]   BUS_DATA_IN;
   logic [7:0]   BUS_DATA_OUT;
   logic         BUS_WR;
   logic         BUS_RD;
   logic [3:0]   REQ_EMPTY;
   logic [127:0] REQ_DATA;
   logic [3:0]   REQ_READ;
   logic         FIFO_READ;
   logic         FIFO_EMPTY;
   logic [31:0]  FIFO_DATA;

   mono_rx_arbiter #(.ABUSWIDTH(16), .NREQ(4), .BURST(16), .VERSION(1)) dut (
      .BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST), .BUS_ADD(BUS_ADD), .BUS_DATA_IN(BUS_DATA_IN),
      .BUS_DATA_OUT(BUS_DATA_OUT), .BUS_WR(BUS_WR), .BUS_RD(BUS_RD),
      .REQ_EMPTY(REQ_EMPTY), .REQ_DATA(REQ_DATA), .REQ_READ(REQ_READ),
      .FIFO_READ(FIFO_READ), .FIFO_EMPTY(FIFO_EMPTY), .FIFO_DATA(FIFO_DATA)
   );

   always #5 BUS_CLK = ~BUS_CLK;

   int          vectors = 0;
   int          errors  = 0;
   int          cyc     = 0;
   int          seq     = 0;
   logic [31:0] src_q [4][$];
   logic [31:0] sb [$];
   int          out_src [$];
   int          out_cyc [$];
   int          pop_src [$];
   int          pop_cyc [$];
   int          pop_cnt [4];
   logic [3:0]  s_rr;

   task automatic clear_logs();
      out_src.delete(); out_cyc.delete(); pop_src.delete(); pop_cyc.delete();
      for (int i = 0; i < 4; i++) pop_cnt[i] = 0;
   endtask

   task automatic load(input int s, input int n);
      for (int j = 0; j < n; j++) begin
         src_q[s].push_back({4'hA, 4'(s), 24'(seq)});
         seq++;
      end
   endtask

   // One clock: present source heads, sample mid-cycle, retire/capture words, advance.
   task automatic cycle();
      logic        s_empty;
      logic [31:0] s_data;
      logic [31:0] exp;
      for (int i = 0; i < 4; i++) begin
         REQ_EMPTY[i]         = (src_q[i].size() == 0);
         REQ_DATA[32*i +: 32] = (src_q[i].size() != 0) ? src_q[i][0] : 32'd0;
      end
      #3;
      s_rr    = REQ_READ;
      s_empty = FIFO_EMPTY;
      s_data  = FIFO_DATA;
      vectors++;
      if ($countones(s_rr) > 1 || (s_rr != 0 && !s_empty && !FIFO_READ)) begin
         errors++;
         $display("FAIL pop_legal: REQ_READ=%b FIFO_EMPTY=%b FIFO_READ=%b", s_rr, s_empty, FIFO_READ);
      end
      if (FIFO_READ && !s_empty) begin
         vectors++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL out_unexpected: got %h, expected no word", s_data);
         end else begin
            exp = sb.pop_front();
            if (s_data !== exp) begin
               errors++;
               $display("FAIL out_data: got %h expected %h", s_data, exp);
            end
         end
         out_src.push_back(int'(s_data[27:24]));
         out_cyc.push_back(cyc);
      end
      for (int i = 0; i < 4; i++) begin
         if (s_rr[i]) begin
            if (src_q[i].size() == 0) begin
               errors++;
               $display("FAIL pop_empty: src %0d popped while empty", i);
            end else begin
               sb.push_back(src_q[i].pop_front());
            end
            pop_cnt[i]++;
            pop_src.push_back(i);
            pop_cyc.push_back(cyc);
         end
      end
      @(posedge BUS_CLK);
      #1;
      cyc++;
   endtask

   task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
      BUS_ADD = a; BUS_DATA_IN = d; BUS_WR = 1'b1;
      cycle();
      BUS_WR = 1'b0;
   endtask

   task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
      BUS_ADD = a; BUS_RD = 1'b1;
      cycle();
      BUS_RD = 1'b0;
      d = BUS_DATA_OUT;
   endtask

   task automatic soft_reset();
      bus_write(16'd0, 8'd0);
      for (int i = 0; i < 4; i++) src_q[i].delete();
      sb.delete();
      clear_logs();
   endtask

   task automatic test_reset();
      logic [7:0] d;
      BUS_RST = 1'b1;
      repeat (3) cycle();
      BUS_RST = 1'b0;
      cycle();
      vectors++; if (FIFO_EMPTY !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", FIFO_EMPTY); end
      vectors++; if (REQ_READ !== 4'b0) begin errors++; $display("FAIL reset_req_read: got %b expected 0000", REQ_READ); end
      vectors++; if (FIFO_DATA !== 32'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", FIFO_DATA); end
      vectors++; if (BUS_DATA_OUT !== 8'd0) begin errors++; $display("FAIL reset_bus_out: got %h expected 00", BUS_DATA_OUT); end
      bus_read(16'd0, d);
      vectors++; if (d !== 8'd1) begin errors++; $display("FAIL reg_version: got %h expected 01", d); end
      bus_read(16'd1, d);
      vectors++; if (d !== 8'd0) begin errors++; $display("FAIL reset_mask: got %h expected 00", d); end
      bus_read(16'd2, d);
      vectors++; if (d !== 8'd0) begin errors++; $display("FAIL reset_status: got %h expected 00", d); end
      bus_read(16'd3, d);
      vectors++; if (d !== 8'd0) begin errors++; $display("FAIL reset_cnt0: got %h expected 00", d); end
      bus_read(16'd9, d);
      vectors++; if (d !== 8'd0) begin errors++; $display("FAIL reg_unmapped: got %h expected 00", d); end
   endtask

   task automatic test_single_source();
      logic [7:0] d;
      soft_reset();
      bus_write(16'd1, 8'h0F);
      clear_logs();
      load(0, 3);
      FIFO_READ = 1'b1;
      for (int t = 0; t < 20 && out_src.size() < 3; t++) cycle();
      vectors++; if (out_src.size() != 3 || pop_cnt[0] != 3) begin errors++; $display("FAIL single_count: got out=%0d pops=%0d expected 3/3", out_src.size(), pop_cnt[0]); end
      if (out_src.size() == 3 && pop_cyc.size() == 3) begin
         vectors++; if (pop_cyc[2] - pop_cyc[0] != 2) begin errors++; $display("FAIL single_pop_consec: got span %0d expected 2", pop_cyc[2] - pop_cyc[0]); end
         vectors++; if (out_cyc[0] != pop_cyc[0] + 1) begin errors++; $display("FAIL single_latency: got %0d expected %0d", out_cyc[0], pop_cyc[0] + 1); end
         vectors++; if (out_cyc[2] - out_cyc[0] != 2) begin errors++; $display("FAIL single_out_consec: got span %0d expected 2", out_cyc[2] - out_cyc[0]); end
      end
      repeat (2) cycle();
      bus_read(16'd3, d);
      vectors++; if (d !== 8'd3) begin errors++; $display("FAIL single_wordcnt: got %0d expected 3", d); end
      bus_read(16'd2, d);
      vectors++; if (d !== 8'h00) begin errors++; $display("FAIL single_status: got %h expected 00", d); end
      FIFO_READ = 1'b0;
   endtask

   task automatic test_round_robin();
      soft_reset();
      bus_write(16'd1, 8'h0F);
      clear_logs();
      for (int s = 0; s < 4; s++) load(s, 40);
      FIFO_READ = 1'b1;
      for (int t = 0; t < 400 && out_src.size() < 96; t++) cycle();
      vectors++; if (out_src.size() < 96) begin errors++; $display("FAIL rr_timeout: got %0d words expected 96", out_src.size()); end
      for (int k = 0; k < 96 && k < out_src.size(); k++) begin
         vectors++;
         if (out_src[k] != (k / 16) % 4) begin errors++; $display("FAIL rr_order: word %0d src %0d expected %0d", k, out_src[k], (k / 16) % 4); end
         if (k > 0) begin
            vectors++;
            if (out_cyc[k] - out_cyc[k-1] != ((k % 16 == 0) ? 2 : 1)) begin
               errors++; $display("FAIL rr_gap: word %0d gap %0d expected %0d", k, out_cyc[k] - out_cyc[k-1], (k % 16 == 0) ? 2 : 1);
            end
         end
      end
      FIFO_READ = 1'b0;
   endtask

   task automatic test_backpressure();
      logic [7:0] d;
      soft_reset();
      bus_write(16'd1, 8'h0F);
      clear_logs();
      load(1, 5);
      FIFO_READ = 1'b0;
      repeat (10) cycle();
      vectors++; if (pop_cnt[1] != 1) begin errors++; $display("FAIL bp_single_pop: got %0d expected 1", pop_cnt[1]); end
      vectors++; if (FIFO_EMPTY !== 1'b0) begin errors++; $display("FAIL bp_held: got FIFO_EMPTY %b expected 0", FIFO_EMPTY); end
      bus_read(16'd2, d);
      vectors++; if (d !== 8'h81) begin errors++; $display("FAIL bp_status: got %h expected 81", d); end
      vectors++; if (pop_cnt[1] != 1) begin errors++; $display("FAIL bp_still_one: got %0d expected 1", pop_cnt[1]); end
      FIFO_READ = 1'b1;
      for (int t = 0; t < 30 && out_src.size() < 5; t++) cycle();
      vectors++; if (out_src.size() != 5 || pop_cnt[1] != 5) begin errors++; $display("FAIL bp_drain: got out=%0d pops=%0d expected 5/5", out_src.size(), pop_cnt[1]); end
      FIFO_READ = 1'b0;
   endtask

   task automatic test_mask();
      soft_reset();
      bus_write(16'd1, 8'h05);
      clear_logs();
      for (int s = 0; s < 4; s++) load(s, 20);
      FIFO_READ = 1'b1;
      for (int t = 0; t < 200 && out_src.size() < 32; t++) cycle();
      vectors++; if (pop_cnt[1] != 0 || pop_cnt[3] != 0) begin errors++; $display("FAIL mask_disabled: got pops1=%0d pops3=%0d expected 0/0", pop_cnt[1], pop_cnt[3]); end
      vectors++; if (out_src.size() < 32) begin errors++; $display("FAIL mask_timeout: got %0d words expected 32", out_src.size()); end
      for (int k = 0; k < 32 && k < out_src.size(); k++) begin
         vectors++;
         if (out_src[k] != ((k < 16) ? 0 : 2)) begin errors++; $display("FAIL mask_order: word %0d src %0d expected %0d", k, out_src[k], (k < 16) ? 0 : 2); end
      end
      FIFO_READ = 1'b0;
   endtask

   task automatic test_mask_clear();
      logic [7:0] d;
      int         npop;
      soft_reset();
      bus_write(16'd1, 8'h0F);
      clear_logs();
      load(0, 10);
      load(1, 10);
      FIFO_READ = 1'b1;
      for (int t = 0; t < 20 && pop_cnt[0] < 3; t++) cycle();
      bus_write(16'd1, 8'h0E);
      bus_read(16'd2, d);
      vectors++; if (s_rr[0] !== 1'b0) begin errors++; $display("FAIL mclr_no_pop: got REQ_READ[0]=%b expected 0", s_rr[0]); end
      vectors++; if (d !== 8'h80) begin errors++; $display("FAIL mclr_status_busy: got %h expected 80", d); end
      bus_read(16'd2, d);
      vectors++; if (d !== 8'h00) begin errors++; $display("FAIL mclr_status_idle: got %h expected 00", d); end
      npop = pop_src.size();
      for (int t = 0; t < 10 && pop_src.size() == npop; t++) cycle();
      vectors++; if (pop_src.size() == npop || pop_src[npop] != 1) begin errors++; $display("FAIL mclr_next_src: got pops=%0d expected next pop from src 1", pop_src.size() - npop); end
      vectors++; if (pop_cnt[0] != 4) begin errors++; $display("FAIL mclr_src0_pops: got %0d expected 4", pop_cnt[0]); end
      FIFO_READ = 1'b0;
   endtask

   task automatic test_saturate_soft_reset();
      logic [7:0] d;
      soft_reset();
      bus_write(16'd4 - 16'd3, 8'h04);
      clear_logs();
      load(2, 300);
      FIFO_READ = 1'b1;
      for (int t = 0; t < 1000 && out_src.size() < 300; t++) cycle();
      vectors++; if (out_src.size() != 300) begin errors++; $display("FAIL sat_count: got %0d expected 300", out_src.size()); end
      repeat (2) cycle();
      bus_read(16'd5, d);
      vectors++; if (d !== 8'd255) begin errors++; $display("FAIL sat_wordcnt2: got %0d expected 255", d); end
      bus_read(16'd3, d);
      vectors++; if (d !== 8'd0) begin errors++; $display("FAIL sat_wordcnt0: got %0d expected 0", d); end
      bus_read(16'd1, d);
      vectors++; if (d !== 8'h04) begin errors++; $display("FAIL sat_mask: got %h expected 04", d); end
      FIFO_READ = 1'b0;
      load(2, 2);
      repeat (5) cycle();
      vectors++; if (FIFO_EMPTY !== 1'b0) begin errors++; $display("FAIL srst_pre_full: got %b expected 0", FIFO_EMPTY); end
      FIFO_READ = 1'b1;
      BUS_ADD = 16'd0; BUS_DATA_IN = 8'd0; BUS_WR = 1'b1;
      cycle();
      BUS_WR = 1'b0;
      FIFO_READ = 1'b0;
      vectors++; if (s_rr !== 4'b0) begin errors++; $display("FAIL srst_no_pop: got %b expected 0000", s_rr); end
      vectors++; if (FIFO_EMPTY !== 1'b1) begin errors++; $display("FAIL srst_empty: got %b expected 1", FIFO_EMPTY); end
      vectors++; if (FIFO_DATA !== 32'd0) begin errors++; $display("FAIL srst_data: got %h expected 0", FIFO_DATA); end
      vectors++; if (BUS_DATA_OUT !== 8'h04) begin errors++; $display("FAIL srst_bus_out_kept: got %h expected 04", BUS_DATA_OUT); end
      for (int i = 0; i < 4; i++) src_q[i].delete();
      sb.delete();
      bus_read(16'd5, d);
      vectors++; if (d !== 8'd0) begin errors++; $display("FAIL srst_wordcnt2: got %0d expected 0", d); end
      bus_read(16'd1, d);
      vectors++; if (d !== 8'd0) begin errors++; $display("FAIL srst_mask: got %h expected 00", d); end
   endtask

   initial begin
      BUS_RST = 1'b1; BUS_ADD = '0; BUS_DATA_IN = '0; BUS_WR = 1'b0; BUS_RD = 1'b0;
      REQ_EMPTY = '1; REQ_DATA = '0; FIFO_READ = 1'b0; s_rr = '0;
      clear_logs();
      @(posedge BUS_CLK);
      #1;
      test_reset();
      test_single_source();
      test_round_robin();
      test_backpressure();
      test_mask();
      test_mask_clear();
      test_saturate_soft_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

`default_nettype wire
